// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: operand/result valid-ready bundle for serial_subtractor.
// SERIAL_SUB_OVF_EN adds the signed-overflow result bit ovf.
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout
`ifdef SERIAL_SUB_OVF_EN
        , ovf
`endif
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout
`ifdef SERIAL_SUB_OVF_EN
        , ovf
`endif
    );
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, through one full-adder slice (a + ~b + ~bin).
// SERIAL_SUB_OVF_EN adds a signed-overflow output ovf captured alongside bout.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input logic               clk,
    input logic               rst,
    serial_subtractor_if.slave io
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
    logic [CW-1:0]    count_q, count_d;
    logic             carry_q, carry_d, bout_q, bout_d;
    logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic             s_bit, c_out, nb;
`ifdef SERIAL_SUB_OVF_EN
    logic             cmsb_q, cmsb_d, ovf_q, ovf_d;
`endif

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        diff_d      = diff_q;
        count_d     = count_q;
        carry_d     = carry_q;
        bout_d      = bout_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
`ifdef SERIAL_SUB_OVF_EN
        cmsb_d      = cmsb_q;
        ovf_d       = ovf_q;
`endif
        nb    = ~b_q[0];
        s_bit = a_q[0] ^ nb ^ carry_q;
        c_out = (a_q[0] & nb) | (a_q[0] & carry_q) | (nb & carry_q);
        unique case (state_q)
            IDLE: if (io.in_valid) begin
                a_d        = io.a;
                b_d        = io.b;
                carry_d    = ~io.bin;
                count_d    = '0;
                in_ready_d = 1'b0;
                state_d    = SHIFT;
            end
            SHIFT: if (count_q == CW'(WIDTH)) begin
                // The extra SHIFT cycle publishes the finished result into the held output regs
                diff_d      = res_q;
                bout_d      = ~carry_q;
                out_valid_d = 1'b1;
                state_d     = DONE;
`ifdef SERIAL_SUB_OVF_EN
                ovf_d       = cmsb_q ^ carry_q;
`endif
            end else begin
                res_d   = {s_bit, res_q[WIDTH-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = c_out;
                count_d = count_q + CW'(1);
`ifdef SERIAL_SUB_OVF_EN
                if (count_q == CW'(WIDTH - 1)) cmsb_d = carry_q;
`endif
            end
            DONE: if (io.out_ready) begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            diff_q      <= '0;
            count_q     <= '0;
            carry_q     <= 1'b0;
            bout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            cmsb_q      <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            diff_q      <= diff_d;
            count_q     <= count_d;
            carry_q     <= carry_d;
            bout_q      <= bout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef SERIAL_SUB_OVF_EN
            cmsb_q      <= cmsb_d;
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign io.in_ready  = in_ready_q;
    assign io.out_valid = out_valid_q;
    assign io.diff      = diff_q;
    assign io.bout      = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign io.ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed + random operand sequence against a queued arithmetic model.
module tb_serial_subtractor;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(W)) io ();
    serial_subtractor #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .io(io.slave));

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } exp_t;

    exp_t sb[$];
    int   n_run  = 0;
    int   n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        exp_t         e;
        logic [W:0]   r;
        int           sa, sbv, sr;
        r    = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
        e.d  = r[W-1:0];
        e.bo = r[W];
        sa   = $signed(a);
        sbv  = $signed(b);
        sr   = sa - sbv - int'(bin);
        e.ov = (sr < -(2 ** (W - 1))) || (sr > 2 ** (W - 1) - 1);
        return e;
    endfunction

    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        int k = 0;
        while (!io.in_ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("in_ready_wait", 32'(io.in_ready), 1);
        io.a = a; io.b = b; io.bin = bin; io.in_valid = 1'b1;
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        sb.push_back(model(a, b, bin));
    endtask

    task automatic wait_out(input string tag);
        int k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!io.out_valid && k < 20);
        check({tag, "_latency"}, 32'(k), W + 1);
    endtask

    task automatic take(input string tag);
        exp_t e;
        check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_diff"}, 32'(io.diff), 32'(e.d));
            check({tag, "_bout"}, 32'(io.bout), 32'(e.bo));
`ifdef SERIAL_SUB_OVF_EN
            check({tag, "_ovf"}, 32'(io.ovf), 32'(e.ov));
`endif
        end
        io.out_ready = 1'b1;
        @(posedge clk); #1;
        io.out_ready = 1'b0;
        check({tag, "_out_valid_drop"}, 32'(io.out_valid), 0);
        check({tag, "_in_ready_back"}, 32'(io.in_ready), 1);
    endtask

    task automatic op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        accept(a, b, bin);
        wait_out(tag);
        take(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        io.in_valid = 1'b0; io.a = '0; io.b = '0; io.bin = 1'b0; io.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(io.in_ready), 1);
        check("rst_out_valid", 32'(io.out_valid), 0);
        check("rst_diff", 32'(io.diff), 0);
        check("rst_bout", 32'(io.bout), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        check("model_9m3", 32'(model(4'd9, 4'd3, 1'b0).d), 32'h6);
        op("sub_9_3", 4'd9, 4'd3, 1'b0);
        op("sub_3_9", 4'd3, 4'd9, 1'b0);
        op("sub_5_5_b", 4'd5, 4'd5, 1'b1);
        op("wrap_0_0_b", 4'd0, 4'd0, 1'b1);
        op("sub_0_1", 4'd0, 4'd1, 1'b0);
        op("ovf_8_1", 4'd8, 4'd1, 1'b0);
        op("novf_7_1", 4'd7, 4'd1, 1'b0);

        // stall in DONE while offering an operand that must be ignored
        accept(4'd6, 4'd2, 1'b0);
        wait_out("stall");
        io.a = 4'd1; io.b = 4'd1; io.bin = 1'b0; io.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("stall_out_valid", 32'(io.out_valid), 1);
            check("stall_diff", 32'(io.diff), 32'h4);
            check("stall_in_ready", 32'(io.in_ready), 0);
        end
        io.in_valid = 1'b0;
        take("stall");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("ignored_no_result", 32'(io.out_valid), 0);
        end

        // reset in the middle of a SHIFT; the partial result is discarded
        io.a = 4'd9; io.b = 4'd2; io.bin = 1'b0; io.in_valid = 1'b1;
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        @(posedge clk); #1;
        check("mid_in_ready_busy", 32'(io.in_ready), 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_in_ready", 32'(io.in_ready), 1);
        check("midrst_out_valid", 32'(io.out_valid), 0);
        check("midrst_diff", 32'(io.diff), 0);
        check("midrst_bout", 32'(io.bout), 0);
        repeat (W + 3) @(posedge clk);
        #1;
        check("midrst_no_result", 32'(io.out_valid), 0);
        op("after_rst_0_0", 4'd0, 4'd0, 1'b0);

        for (int i = 0; i < 8; i++)
            op("rand", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));

        check("sb_drained", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
